// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester memory-port arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam int DEFAULT_LINE_WORDS = 4;

endpackage

// File: rtl/mem_rr_pick.sv
// Combinational 2-way round-robin picker: on a tie, the requester that did not win last time is chosen.
module mem_rr_pick
    import mem_arbiter_pkg::*;
(
    input  logic   ic_req,
    input  logic   dc_req,
    input  owner_e last_owner,
    output logic   valid,
    output owner_e owner
);

    always_comb begin
        valid = ic_req | dc_req;
        owner = OWN_I;
        if (ic_req && dc_req) begin
            owner = (last_owner == OWN_I) ? OWN_D : OWN_I;
        end else if (dc_req) begin
            owner = OWN_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the I-cache and D-cache refill/writeback engines onto one memory port,
// sequencing each grant as a line of single-beat transactions with one beat outstanding.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LINE_WORDS = DEFAULT_LINE_WORDS,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_gnt,
    output logic              ic_rvalid,
    output logic [31:0]       ic_rdata,
    output logic              ic_done,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [31:0]       dc_wdata,
    output logic              dc_gnt,
    output logic              dc_rvalid,
    output logic [31:0]       dc_rdata,
    output logic              dc_done,
    output logic              dc_wnext,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam int K      = BEAT_W + 2;
    localparam int BASE_W = ADDR_W - K;

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_owner_q, last_owner_d;
    logic              we_q, we_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [BASE_W-1:0] base_q, base_d;

    logic   pick_valid;
    owner_e pick_owner;
    logic   last_beat;
    logic   busy;
    logic   is_d;
    logic   rd_fwd;
    logic   unused_addr_bits;

    // Word-within-line bits of the request address never reach the memory port.
    assign unused_addr_bits = ^{ic_addr[K-1:0], dc_addr[K-1:0]};

    mem_rr_pick u_pick (
        .ic_req     (ic_req),
        .dc_req     (dc_req),
        .last_owner (last_owner_q),
        .valid      (pick_valid),
        .owner      (pick_owner)
    );

    assign last_beat = &beat_q;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        beat_d       = beat_q;
        base_d       = base_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_d      = pick_owner;
                    last_owner_d = pick_owner;
                    base_d       = (pick_owner == OWN_D) ? dc_addr[ADDR_W-1:K] : ic_addr[ADDR_W-1:K];
                    we_d         = (pick_owner == OWN_D) && dc_we;
                    beat_d       = '0;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_ready) begin
                    if (!we_q) begin
                        state_d = ST_WAIT;
                    end else if (last_beat) begin
                        state_d = ST_DONE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    if (last_beat) begin
                        state_d = ST_DONE;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset leaves last_owner at D so the I-cache wins the first tie.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_I;
            last_owner_q <= OWN_D;
            we_q         <= 1'b0;
            beat_q       <= '0;
            base_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            beat_q       <= beat_d;
            base_q       <= base_d;
        end
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        is_d      = (owner_q == OWN_D);
        rd_fwd    = (state_q == ST_WAIT) && mem_rvalid;
        ic_gnt    = busy && !is_d;
        dc_gnt    = busy && is_d;
        mem_req   = (state_q == ST_ISSUE);
        mem_we    = busy && we_q;
        mem_addr  = busy ? {base_q, beat_q, 2'b00} : '0;
        mem_wdata = (busy && we_q) ? dc_wdata : 32'h0;
        ic_rvalid = rd_fwd && !is_d;
        ic_rdata  = (rd_fwd && !is_d) ? mem_rdata : 32'h0;
        dc_rvalid = rd_fwd && is_d;
        dc_rdata  = (rd_fwd && is_d) ? mem_rdata : 32'h0;
        ic_done   = (state_q == ST_DONE) && !is_d;
        dc_done   = (state_q == ST_DONE) && is_d;
        dc_wnext  = mem_req && mem_ready && mem_we;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a cycle-stepped memory model feeds the DUT, expected beats are queued up front.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ic_req = 1'b0;
    logic [31:0] ic_addr = '0;
    logic        ic_gnt, ic_rvalid, ic_done;
    logic [31:0] ic_rdata;
    logic        dc_req = 1'b0;
    logic        dc_we = 1'b0;
    logic [31:0] dc_addr = '0;
    logic [31:0] dc_wdata = '0;
    logic        dc_gnt, dc_rvalid, dc_done, dc_wnext;
    logic [31:0] dc_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    int          ready_hold = 0;
    int          rv_delay = 0;
    int          rv_cnt = -1;
    logic [31:0] rv_addr = '0;
    bit          inject_rv = 1'b0;

    logic [136:0] all_outs;
    assign all_outs = {ic_gnt, ic_rvalid, ic_rdata, ic_done, dc_gnt, dc_rvalid, dc_rdata, dc_done,
                       dc_wnext, mem_req, mem_we, mem_addr, mem_wdata};

    always #5 clk = ~clk;

    mem_arbiter #(.LINE_WORDS(4), .ADDR_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_rvalid(ic_rvalid),
        .ic_rdata(ic_rdata), .ic_done(ic_done),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_gnt(dc_gnt), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata), .dc_done(dc_done),
        .dc_wnext(dc_wnext),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic void push_line(input logic [31:0] base, input bit rd);
        for (int b = 0; b < 4; b++) begin
            exp_addr_q.push_back(base + 32'(b * 4));
            if (rd) exp_data_q.push_back(mem_word(base + 32'(b * 4)));
        end
    endfunction

    // Memory model, called once per cycle just after the falling edge.
    task automatic mem_step();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        if (rv_cnt > 0) rv_cnt--;
        else if (rv_cnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(rv_addr);
            rv_cnt     = -1;
        end
        if (inject_rv) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEAD_BEEF;
            inject_rv  = 1'b0;
        end
        mem_ready = (ready_hold == 0);
        if (mem_req && ready_hold > 0) ready_hold--;
        if (mem_req && mem_ready && !mem_we) begin
            rv_cnt  = rv_delay;
            rv_addr = mem_addr;
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
        ic_addr = '0; dc_addr = '0; dc_wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        rv_cnt = -1; ready_hold = 0; rv_delay = 0; inject_rv = 1'b0;
        exp_addr_q.delete();
        exp_data_q.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #1;
        n_checks++;
        if (all_outs !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %h want 0", all_outs);
        end
        do_reset();
        @(negedge clk); mem_step(); #1;
        n_checks++;
        if (all_outs !== '0) begin
            n_fail++;
            $display("[TB] FAIL idle_outputs: got %h want 0", all_outs);
        end
    endtask

    task automatic test_ic_read();
        int done_at = -1;
        int rv_seen = 0;
        logic [31:0] exp_v;
        ic_addr = 32'h0000_1234;
        push_line(32'h0000_1230, 1'b1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); mem_step(); if (i == 0) ic_req = 1'b1; #1;
            if (i == 1) begin
                n_checks++;
                if ({ic_gnt, dc_gnt, mem_req} !== 3'b101) begin
                    n_fail++;
                    $display("[TB] FAIL ic_read_gnt: got %b want 101", {ic_gnt, dc_gnt, mem_req});
                end
            end
            if (mem_req && mem_ready) begin
                exp_v = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 'x;
                n_checks++;
                if (mem_addr !== exp_v) begin
                    n_fail++;
                    $display("[TB] FAIL ic_read_addr: got %h want %h", mem_addr, exp_v);
                end
            end
            if (ic_rvalid) begin
                rv_seen++;
                exp_v = (exp_data_q.size() != 0) ? exp_data_q.pop_front() : 'x;
                n_checks++;
                if (ic_rdata !== exp_v) begin
                    n_fail++;
                    $display("[TB] FAIL ic_read_data: got %h want %h", ic_rdata, exp_v);
                end
            end
            if (ic_done) begin done_at = i; ic_req = 1'b0; break; end
        end
        n_checks++;
        if (done_at != 9) begin n_fail++; $display("[TB] FAIL ic_read_done_cycle: got %0d want 9", done_at); end
        n_checks++;
        if (rv_seen != 4) begin n_fail++; $display("[TB] FAIL ic_read_rvalid_count: got %0d want 4", rv_seen); end
    endtask

    task automatic test_dc_write();
        int done_at = -1;
        int wnext_n = 0;
        int wd_idx = 0;
        logic [31:0] exp_a, exp_w;
        dc_we = 1'b1;
        dc_addr = 32'h0000_2000;
        dc_wdata = 32'h1111_0000;
        push_line(32'h0000_2000, 1'b0);
        for (int b = 0; b < 4; b++) exp_data_q.push_back(32'h1111_0000 + 32'(b));
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); mem_step(); if (i == 0) dc_req = 1'b1; #1;
            if (mem_req && mem_ready) begin
                exp_a = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 'x;
                exp_w = (exp_data_q.size() != 0) ? exp_data_q.pop_front() : 'x;
                n_checks++;
                if ({mem_addr, mem_we, mem_wdata} !== {exp_a, 1'b1, exp_w}) begin
                    n_fail++;
                    $display("[TB] FAIL dc_write_beat: got addr %h we %b wdata %h want addr %h we 1 wdata %h",
                             mem_addr, mem_we, mem_wdata, exp_a, exp_w);
                end
            end
            if (dc_wnext) begin
                wnext_n++;
                wd_idx++;
                dc_wdata = 32'h1111_0000 + 32'(wd_idx);
            end
            if (dc_done) begin done_at = i; dc_req = 1'b0; dc_we = 1'b0; break; end
        end
        n_checks++;
        if (done_at != 5) begin n_fail++; $display("[TB] FAIL dc_write_done_cycle: got %0d want 5", done_at); end
        n_checks++;
        if (wnext_n != 4) begin n_fail++; $display("[TB] FAIL dc_write_wnext_count: got %0d want 4", wnext_n); end
        @(negedge clk); mem_step(); #1;
        n_checks++;
        if ({dc_gnt, mem_we, mem_wdata} !== 34'h0) begin
            n_fail++;
            $display("[TB] FAIL dc_write_idle_mux: got %h want 0", {dc_gnt, mem_we, mem_wdata});
        end
    endtask

    task automatic test_tie();
        int ic_g1 = -1, ic_d1 = -1, dc_g = -1, dc_d = -1, ic_g2 = -1, ic_d2 = -1;
        logic prev_ic = 1'b0, prev_dc = 1'b0;
        logic [31:0] exp_v, got_v;
        do_reset();
        ic_addr = 32'h0000_4000;
        dc_addr = 32'h0000_3000;
        push_line(32'h0000_4000, 1'b1);
        push_line(32'h0000_3000, 1'b1);
        push_line(32'h0000_4000, 1'b1);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk); mem_step(); if (i == 0) begin ic_req = 1'b1; dc_req = 1'b1; end #1;
            if (ic_gnt && !prev_ic) begin if (ic_g1 < 0) ic_g1 = i; else ic_g2 = i; end
            if (dc_gnt && !prev_dc && dc_g < 0) dc_g = i;
            prev_ic = ic_gnt;
            prev_dc = dc_gnt;
            if (mem_req && mem_ready) begin
                exp_v = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 'x;
                n_checks++;
                if (mem_addr !== exp_v) begin
                    n_fail++;
                    $display("[TB] FAIL tie_addr: got %h want %h", mem_addr, exp_v);
                end
            end
            if (ic_rvalid || dc_rvalid) begin
                got_v = ic_rvalid ? ic_rdata : dc_rdata;
                exp_v = (exp_data_q.size() != 0) ? exp_data_q.pop_front() : 'x;
                n_checks++;
                if (got_v !== exp_v) begin
                    n_fail++;
                    $display("[TB] FAIL tie_data: got %h want %h", got_v, exp_v);
                end
            end
            if (dc_done) begin dc_d = i; ic_req = 1'b1; end
            if (ic_done) begin
                if (ic_d1 < 0) begin ic_d1 = i; ic_req = 1'b0; end
                else begin ic_d2 = i; ic_req = 1'b0; dc_req = 1'b0; break; end
            end
        end
        n_checks++;
        if ({ic_g1, ic_d1, dc_g} != {32'sd1, 32'sd9, 32'sd11}) begin
            n_fail++;
            $display("[TB] FAIL tie_first_round: got ic_gnt %0d ic_done %0d dc_gnt %0d want 1 9 11", ic_g1, ic_d1, dc_g);
        end
        n_checks++;
        if (dc_d != 19) begin n_fail++; $display("[TB] FAIL tie_dc_done: got %0d want 19", dc_d); end
        n_checks++;
        if ({ic_g2, ic_d2} != {32'sd21, 32'sd29}) begin
            n_fail++;
            $display("[TB] FAIL tie_second_round: got ic_gnt %0d ic_done %0d want 21 29", ic_g2, ic_d2);
        end
    endtask

    task automatic test_stall();
        int done_at = -1;
        int rv_seen = 0;
        logic [31:0] exp_v;
        ic_addr = 32'h0000_5000;
        push_line(32'h0000_5000, 1'b1);
        ready_hold = 3;
        rv_delay = 5;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk); mem_step(); if (i == 0) ic_req = 1'b1; #1;
            if (i >= 1 && i <= 3) begin
                n_checks++;
                if ({mem_req, mem_ready, mem_addr} !== {1'b1, 1'b0, 32'h0000_5000}) begin
                    n_fail++;
                    $display("[TB] FAIL stall_issue_hold: got req %b addr %h want req 1 addr 00005000", mem_req, mem_addr);
                end
            end
            if (i >= 5 && i <= 9) begin
                n_checks++;
                if ({ic_gnt, mem_req, ic_rvalid} !== 3'b100) begin
                    n_fail++;
                    $display("[TB] FAIL stall_wait_hold: got %b want 100", {ic_gnt, mem_req, ic_rvalid});
                end
            end
            if (mem_req && mem_ready) begin
                exp_v = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 'x;
                n_checks++;
                if (mem_addr !== exp_v) begin n_fail++; $display("[TB] FAIL stall_addr: got %h want %h", mem_addr, exp_v); end
            end
            if (ic_rvalid) begin
                rv_seen++;
                exp_v = (exp_data_q.size() != 0) ? exp_data_q.pop_front() : 'x;
                n_checks++;
                if (ic_rdata !== exp_v) begin n_fail++; $display("[TB] FAIL stall_data: got %h want %h", ic_rdata, exp_v); end
            end
            if (ic_done) begin done_at = i; ic_req = 1'b0; break; end
        end
        rv_delay = 0;
        n_checks++;
        if (done_at != 32) begin n_fail++; $display("[TB] FAIL stall_done_cycle: got %0d want 32", done_at); end
        n_checks++;
        if (rv_seen != 4) begin n_fail++; $display("[TB] FAIL stall_rvalid_count: got %0d want 4", rv_seen); end
    endtask

    task automatic test_spurious();
        int done_at = -1;
        int rv_seen = 0;
        logic [31:0] exp_v;
        inject_rv = 1'b1;
        @(negedge clk); mem_step(); #1;
        n_checks++;
        if ({ic_rvalid, dc_rvalid, ic_rdata, dc_rdata} !== 66'h0) begin
            n_fail++;
            $display("[TB] FAIL spurious_idle: got %h want 0", {ic_rvalid, dc_rvalid, ic_rdata, dc_rdata});
        end
        ic_addr = 32'h0000_7000;
        push_line(32'h0000_7000, 1'b1);
        ready_hold = 2;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); if (i == 1) inject_rv = 1'b1; mem_step(); if (i == 0) ic_req = 1'b1; #1;
            if (i == 1) begin
                n_checks++;
                if ({ic_rvalid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h0000_7000}) begin
                    n_fail++;
                    $display("[TB] FAIL spurious_issue: got rvalid %b req %b addr %h want 0 1 00007000", ic_rvalid, mem_req, mem_addr);
                end
            end
            if (mem_req && mem_ready) begin
                exp_v = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 'x;
                n_checks++;
                if (mem_addr !== exp_v) begin n_fail++; $display("[TB] FAIL spurious_addr: got %h want %h", mem_addr, exp_v); end
            end
            if (ic_rvalid) begin
                rv_seen++;
                exp_v = (exp_data_q.size() != 0) ? exp_data_q.pop_front() : 'x;
                n_checks++;
                if (ic_rdata !== exp_v) begin n_fail++; $display("[TB] FAIL spurious_data: got %h want %h", ic_rdata, exp_v); end
            end
            if (ic_done) begin done_at = i; ic_req = 1'b0; break; end
        end
        n_checks++;
        if ({done_at, rv_seen} != {32'sd11, 32'sd4}) begin
            n_fail++;
            $display("[TB] FAIL spurious_completion: got done %0d rvalids %0d want 11 4", done_at, rv_seen);
        end
    endtask

    task automatic test_reset_mid_burst();
        int done_at = -1;
        bit hit = 1'b0;
        logic [31:0] exp_v;
        ic_addr = 32'h0000_6000;
        push_line(32'h0000_6000, 1'b1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); mem_step(); if (i == 0) ic_req = 1'b1; #1;
            if (ic_rvalid) begin
                exp_v = (exp_data_q.size() != 0) ? exp_data_q.pop_front() : 'x;
                n_checks++;
                if (ic_rdata !== exp_v) begin n_fail++; $display("[TB] FAIL midrst_data: got %h want %h", ic_rdata, exp_v); end
            end
            if (mem_req && mem_ready && mem_addr == 32'h0000_6008) begin
                resetn = 1'b0;
                rv_cnt = -1;
                #1;
                n_checks++;
                if (all_outs !== '0) begin n_fail++; $display("[TB] FAIL midrst_outputs: got %h want 0", all_outs); end
                hit = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!hit) begin n_fail++; $display("[TB] FAIL midrst_reach_beat2: got 0 want 1"); end
        exp_addr_q.delete();
        exp_data_q.delete();
        push_line(32'h0000_6000, 1'b1);
        @(negedge clk); mem_step();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); mem_step(); if (i == 0) resetn = 1'b1; #1;
            if (mem_req && mem_ready) begin
                exp_v = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 'x;
                n_checks++;
                if (mem_addr !== exp_v) begin n_fail++; $display("[TB] FAIL midrst_restart_addr: got %h want %h", mem_addr, exp_v); end
            end
            if (ic_rvalid) begin
                exp_v = (exp_data_q.size() != 0) ? exp_data_q.pop_front() : 'x;
                n_checks++;
                if (ic_rdata !== exp_v) begin n_fail++; $display("[TB] FAIL midrst_restart_data: got %h want %h", ic_rdata, exp_v); end
            end
            if (ic_done) begin done_at = i; ic_req = 1'b0; break; end
        end
        n_checks++;
        if (done_at != 9) begin n_fail++; $display("[TB] FAIL midrst_restart_done: got %0d want 9", done_at); end
    endtask

    initial begin
        test_reset();
        test_ic_read();
        test_dc_write();
        test_tie();
        test_stall();
        test_spurious();
        test_reset_mid_burst();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

endmodule
